// File: rtl/kbd_port_if.sv
// CPU-side I/O port bus for the keyboard port: chip select, register select,
// read/write strobes, write data in, read data and interrupt out.
interface kbd_port_if;
  logic       cs;
  logic       rs;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq_n;

  modport slave (
    input  cs, rs, rd_n, wr_n, data_in,
    output data_out, irq_n
  );

  modport master (
    output cs, rs, rd_n, wr_n, data_in,
    input  data_out, irq_n
  );
endinterface

// File: rtl/kbd_port.sv
// Z80 I/O-port keyboard interface: queues PS/2 key events in a small FIFO and
// exposes status/control and scancode registers to the CPU, with optional IRQ.
module kbd_port #(
  parameter int c_depth_bits = 3,
  parameter bit c_irq_init   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  kbd_port_if.slave   bus
);

  localparam int                  c_depth = 1 << c_depth_bits;
  localparam logic [c_depth_bits:0] c_full = {1'b1, {c_depth_bits{1'b0}}};

  logic                    prev_toggle_q;
  logic                    armed_q;
  logic                    rd_data_q;
  logic                    rd_stat_q;
  logic                    wr_ctl_q;
  logic [1:0]              wdata_q;
  logic                    irq_en_q, irq_en_d;
  logic                    ovf_q, ovf_d;
  logic [c_depth_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_depth_bits-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_depth_bits:0]   count_q, count_d;
  logic [9:0]              mem_q [c_depth];

  logic       push_req, pop_req, ovf_clr, ctl_commit, flush;
  logic       full, empty, do_pop, do_push, ovf_set;
  logic [9:0] head;
  logic [7:0] status;
  logic       irq_pend;
  logic       unused_data_in;

  assign unused_data_in = ^bus.data_in[7:2];

  assign push_req   = armed_q & (ps2_key[10] != prev_toggle_q);
  // Access kind is latched while the strobe is low; the action fires on the
  // cycle the strobe is seen high again.
  assign pop_req    = rd_data_q & bus.rd_n;
  assign ovf_clr    = rd_stat_q & bus.rd_n;
  assign ctl_commit = wr_ctl_q & bus.wr_n;
  assign flush      = ctl_commit & wdata_q[1];

  assign full    = (count_q == c_full);
  assign empty   = (count_q == '0);
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & ~flush & (~full | do_pop);
  assign ovf_set = push_req & full & ~do_pop;

  assign head     = mem_q[rd_ptr_q];
  assign irq_pend = irq_en_q & ~empty;

  always_ff @(posedge clk) begin
    prev_toggle_q <= ps2_key[10];
    if (reset) begin
      armed_q   <= 1'b0;
      rd_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
      wr_ctl_q  <= 1'b0;
      wdata_q   <= 2'b00;
      irq_en_q  <= c_irq_init;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      armed_q   <= 1'b1;
      rd_data_q <= bus.cs & bus.rs & ~bus.rd_n;
      rd_stat_q <= bus.cs & ~bus.rs & ~bus.rd_n;
      wr_ctl_q  <= bus.cs & ~bus.rs & ~bus.wr_n;
      if (bus.cs && !bus.wr_n) begin
        wdata_q <= bus.data_in[1:0];
      end
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage needs no reset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= {ps2_key[9], ps2_key[8], ps2_key[7:0]};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (ctl_commit) begin
      irq_en_d = wdata_q[0];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (ovf_clr) begin
        ovf_d = 1'b0;
      end
      if (ovf_set) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    status    = 8'h00;
    status[0] = ~empty;
    status[1] = ovf_q;
    status[2] = ~empty & head[9];
    status[3] = ~empty & head[8];
    status[4] = full;
    status[6] = irq_en_q;
    status[7] = irq_pend;
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.cs && !bus.rd_n) begin
      if (bus.rs) begin
        bus.data_out = empty ? 8'h00 : head[7:0];
      end else begin
        bus.data_out = status;
      end
    end
  end

  assign bus.irq_n = ~irq_pend;

endmodule

// File: tb/tb_kbd_port.sv
// Directed bench for kbd_port: drives CPU port cycles and PS/2 events and
// checks status, data and irq_n against hand-computed values.
module tb_kbd_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  d;

  kbd_port_if bus_if ();

  kbd_port #(
    .c_depth_bits (3),
    .c_irq_init   (1'b0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic push_key(input logic [7:0] code, input logic pr, input logic ex);
    ps2_key = {~ps2_key[10], pr, ex, code};
    tick();
  endtask

  task automatic cpu_read(input logic rsel, input int len, output logic [7:0] rdata);
    bus_if.cs   = 1'b1;
    bus_if.rs   = rsel;
    bus_if.rd_n = 1'b0;
    repeat (len) tick();
    rdata = bus_if.data_out;
    bus_if.rd_n = 1'b1;
    tick();
    bus_if.cs = 1'b0;
    $display("read  rs=%0d data=0x%02h", rsel, rdata);
  endtask

  task automatic cpu_write(input logic [7:0] val);
    bus_if.cs      = 1'b1;
    bus_if.rs      = 1'b0;
    bus_if.data_in = val;
    bus_if.wr_n    = 1'b0;
    tick();
    tick();
    bus_if.wr_n = 1'b1;
    tick();
    bus_if.cs = 1'b0;
    $display("write ctl data=0x%02h", val);
  endtask

  initial begin
    reset          = 1'b1;
    ps2_key        = 11'h400;
    bus_if.cs      = 1'b0;
    bus_if.rs      = 1'b0;
    bus_if.rd_n    = 1'b1;
    bus_if.wr_n    = 1'b1;
    bus_if.data_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // reset with toggle already high
    check("rst_dout", bus_if.data_out, 8'h00);
    check("rst_irq", {7'd0, bus_if.irq_n}, 8'h01);
    cpu_read(1'b0, 2, d);
    check("rst_status", d, 8'h00);
    bus_if.rd_n = 1'b0;
    #1;
    check("cs0_dout", bus_if.data_out, 8'h00);
    bus_if.rd_n = 1'b1;
    tick();

    // push and pop with irq enabled
    cpu_write(8'h01);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    #1;
    check("push_lat_irq_n0", {7'd0, bus_if.irq_n}, 8'h01);
    tick();
    check("push_lat_irq_n1", {7'd0, bus_if.irq_n}, 8'h00);
    cpu_read(1'b0, 2, d);
    check("push_status", d, 8'hC5);
    cpu_read(1'b1, 2, d);
    check("push_data", d, 8'h1C);
    cpu_read(1'b0, 2, d);
    check("pop_status", d, 8'h40);
    check("pop_irq", {7'd0, bus_if.irq_n}, 8'h01);
    cpu_read(1'b1, 2, d);
    check("empty_data", d, 8'h00);

    // overflow with irq disabled
    cpu_write(8'h00);
    for (int i = 1; i <= 9; i++) push_key(8'(i), 1'b0, 1'b0);
    cpu_read(1'b0, 2, d);
    check("ovf_status", d, 8'h13);
    for (int i = 1; i <= 8; i++) begin
      cpu_read(1'b1, 2, d);
      check($sformatf("ovf_data%0d", i), d, 8'(i));
    end
    cpu_read(1'b0, 2, d);
    check("ovf_cleared", d, 8'h00);

    // extended + pressed head bits
    push_key(8'h5A, 1'b1, 1'b1);
    cpu_read(1'b0, 2, d);
    check("ext_status", d, 8'h0D);
    cpu_read(1'b1, 2, d);
    check("ext_data", d, 8'h5A);

    // same-cycle push and pop while full
    for (int i = 0; i < 8; i++) push_key(8'h10 + 8'(i), 1'b0, 1'b0);
    bus_if.cs   = 1'b1;
    bus_if.rs   = 1'b1;
    bus_if.rd_n = 1'b0;
    tick();
    tick();
    check("sc_head", bus_if.data_out, 8'h10);
    bus_if.rd_n = 1'b1;
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h20};
    tick();
    bus_if.cs = 1'b0;
    cpu_read(1'b0, 2, d);
    check("sc_status", d, 8'h11);
    for (int i = 1; i < 8; i++) begin
      cpu_read(1'b1, 2, d);
      check($sformatf("sc_data%0d", i), d, 8'h10 + 8'(i));
    end
    cpu_read(1'b1, 2, d);
    check("sc_last", d, 8'h20);
    cpu_read(1'b0, 2, d);
    check("sc_drained", d, 8'h00);

    // long read strobe pops exactly one
    push_key(8'h31, 1'b0, 1'b0);
    push_key(8'h32, 1'b0, 1'b0);
    cpu_read(1'b1, 40, d);
    check("long_data1", d, 8'h31);
    cpu_read(1'b1, 2, d);
    check("long_data2", d, 8'h32);
    cpu_read(1'b0, 2, d);
    check("long_status", d, 8'h00);

    // flush with a concurrent push
    cpu_write(8'h01);
    push_key(8'h41, 1'b0, 1'b0);
    push_key(8'h42, 1'b0, 1'b0);
    push_key(8'h43, 1'b0, 1'b0);
    check("fl_irq_before", {7'd0, bus_if.irq_n}, 8'h00);
    bus_if.cs      = 1'b1;
    bus_if.rs      = 1'b0;
    bus_if.data_in = 8'h02;
    bus_if.wr_n    = 1'b0;
    tick();
    tick();
    bus_if.wr_n = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h44};
    tick();
    bus_if.cs = 1'b0;
    tick();
    cpu_read(1'b0, 2, d);
    check("fl_status", d, 8'h00);
    check("fl_irq", {7'd0, bus_if.irq_n}, 8'h01);
    cpu_read(1'b1, 2, d);
    check("fl_data", d, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
